cdc_pulse_sender: RTL

// - Fast-to-slow companion of the slow-to-fast edge detector. Carries single-cycle event pulses

---
 rtl/cdc_pkg.sv | 13 +
 rtl/sync_nff.sv | 23 ++
 rtl/cdc_pulse_sender.sv | 113 +++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the fast-to-slow CDC blocks: FSM encoding and default parameters.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ACK_WAIT = 2'd2
    } cdc_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int MIN_HOLD_DEF    = 4;

endpackage

// File: rtl/sync_nff.sv
// N-flop level synchroniser with asynchronous active-high reset; output is the last flop.
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_pulse_sender.sv
// Carries single-cycle event pulses from fast_clk to a slower consumer over a four-phase
// req/ack handshake, with a one-deep pending slot and saturating sent/drop counters.
//
// Handshake: req rises for a new event and stays high until it has been high MIN_HOLD cycles
// and the synchronised ack is high; req then falls and the event counts as sent once ack falls.
module cdc_pulse_sender
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int MIN_HOLD    = MIN_HOLD_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic             event_pulse,
    input  logic             ack_async,
    output logic             req,
    output logic             busy,
    output logic [CNT_W-1:0] sent_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

    cdc_state_t        state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              pending, pending_next;
    logic              ack_sync;
    logic              sent_inc, drop_inc;

    sync_nff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (fast_clk),
        .rst (rst),
        .d   (ack_async),
        .q   (ack_sync)
    );

    // hold_cnt counts completed req-high cycles, so exiting when it reaches MIN_HOLD-1
    // leaves req high for exactly MIN_HOLD cycles when ack is already present.
    always_comb begin
        state_next   = state;
        hold_next    = hold_cnt;
        pending_next = pending;
        sent_inc     = 1'b0;
        drop_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (event_pulse) begin
                    state_next = REQ;
                    hold_next  = '0;
                end
            end
            REQ: begin
                if (hold_cnt < HOLD_MAX) hold_next = hold_cnt + HOLD_W'(1);
                if ((hold_cnt >= HOLD_LAST) && ack_sync) state_next = ACK_WAIT;
                if (event_pulse) begin
                    if (pending) drop_inc = 1'b1;
                    else         pending_next = 1'b1;
                end
            end
            ACK_WAIT: begin
                if (!ack_sync) begin
                    sent_inc = 1'b1;
                    // An event on this cycle either refills the slot being drained, or
                    // passes straight through it when the slot was empty.
                    if (pending || event_pulse) begin
                        state_next   = REQ;
                        hold_next    = '0;
                        pending_next = pending && event_pulse;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (event_pulse) begin
                    if (pending) drop_inc = 1'b1;
                    else         pending_next = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            pending  <= 1'b0;
            req      <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            pending  <= pending_next;
            req      <= (state_next == REQ);
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            sent_count <= '0;
            drop_count <= '0;
        end else begin
            if (sent_inc && (sent_count != '1)) sent_count <= sent_count + CNT_W'(1);
            if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign busy = (state != IDLE) || pending;

endmodule
